// File: rtl/alu_shift_pkg.sv
// Shared types for the ALU shift path: shift operation encoding and the
// sequencer's control states.
package alu_shift_pkg;

  typedef enum logic [1:0] {
    SLL  = 2'b00,
    SRL  = 2'b01,
    SRA  = 2'b10,
    RSVD = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One reusable right-shift stage: shifts by 2**step when enabled, filling the
// vacated MSBs with 'fill'. Left shifts are handled by the caller through bit
// reversal, so only a right shifter is needed here.
module shift_step #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] step,
  input  logic               en,
  input  logic               fill,
  output logic [WIDTH-1:0]   out
);

  logic [2*WIDTH-1:0] ext;
  logic [SHAMT_W-1:0] amt;

  // Extend the operand with fill bits above it so the shift pulls them in.
  always_comb begin
    amt = SHAMT_W'(1) << step;
    ext = {{WIDTH{fill}}, in};
    out = en ? WIDTH'(ext >> amt) : in;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: accepts one SLL/SRL/SRA request, applies one
// power-of-two stage per clock gated by successive shamt bits, then holds the
// result until the consumer takes it. Latency is fixed at SHAMT_W cycles.
module shift_sequencer
  import alu_shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               busy
);

  state_t             state, next_state;
  logic [SHAMT_W-1:0] step;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] shamt_r;
  shift_op_t          op_r;
  shift_op_t          in_op_t;
  logic               fill_r;
  logic [WIDTH-1:0]   in_rev;
  logic [WIDTH-1:0]   acc_rev;
  logic [WIDTH-1:0]   stage_out;
  logic               stage_en;
  logic               last_step;

  assign in_op_t = shift_op_t'(in_op);

  // Bit reversal turns a left shift into a right shift on the way in and back
  // again on the way out.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign in_rev[i]  = in_data[WIDTH-1-i];
    assign acc_rev[i] = acc[WIDTH-1-i];
  end

  // Reserved ops pass through every stage untouched.
  assign stage_en  = (|(shamt_r & (SHAMT_W'(1) << step))) && (op_r != RSVD);
  assign last_step = (step == SHAMT_W'(SHAMT_W - 1));

  shift_step #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_step (
    .in   (acc),
    .step (step),
    .en   (stage_en),
    .fill (fill_r),
    .out  (stage_out)
  );

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath: capture the request on accept, then walk the stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      step    <= '0;
      acc     <= '0;
      shamt_r <= '0;
      op_r    <= SLL;
      fill_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc     <= (in_op_t == SLL) ? in_rev : in_data;
            shamt_r <= in_shamt;
            op_r    <= in_op_t;
            fill_r  <= (in_op_t == SRA) ? in_data[WIDTH-1] : 1'b0;
            step    <= '0;
          end
        end
        SHIFT: begin
          acc  <= stage_out;
          step <= last_step ? '0 : step + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = SHIFT;
      end
      SHIFT: begin
        if (last_step) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign busy     = (state != IDLE);
  assign out_data = (op_r == SLL) ? acc_rev : acc;
  assign out_err  = (op_r == RSVD);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, randomized
// requests against an arithmetic reference model, and hand-written sequences
// for latency, backpressure, throughput and mid-operation reset.
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        busy;

  int tests;
  int fails;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  shift_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and log a failure line if it differs.
  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference behaviour straight from the op definitions.
  function automatic void ref_model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                                    output logic [31:0] e, output logic e_err);
    e_err = 1'b0;
    case (op)
      2'b00:   e = d << s;
      2'b01:   e = d >> s;
      2'b10:   e = $unsigned($signed(d) >>> s);
      default: begin e = d; e_err = 1'b1; end
    endcase
  endfunction

  // Issue one request, scramble inputs after accept, wait for the result,
  // hold off the consumer for 'hold' cycles, then take the result.
  task automatic apply_stimulus(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                                input int hold, output logic [31:0] got, output logic got_err,
                                output int lat);
    logic [31:0] first;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
    check_output("accept_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_op    = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    first = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      check_output("hold_valid", {31'b0, out_valid}, 32'd1);
      check_output("hold_data", out_data, first);
      check_output("hold_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    got       = out_data;
    got_err   = out_err;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] got, exp_d;
    logic        got_err, exp_e;
    int          lat;
    int          cyc, t0, t1, naccept;

    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_shamt = '0;
    in_op = '0;
    out_ready = 1'b0;

    vecs[0] = '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0};
    vecs[1] = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{2'b10, 32'h7000_0000, 5'd28, 32'h0000_0007, 1'b0};
    vecs[3] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    vecs[4] = '{2'b00, 32'hF000_000F, 5'd4,  32'h0000_00F0, 1'b0};
    vecs[5] = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
    vecs[6] = '{2'b11, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check_output("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("reset_out_data", out_data, 32'd0);
    check_output("reset_out_err", {31'b0, out_err}, 32'd0);
    check_output("reset_busy", {31'b0, busy}, 32'd0);

    // Directed vectors.
    foreach (vecs[k]) begin
      apply_stimulus(vecs[k].data, vecs[k].shamt, vecs[k].op, 0, got, got_err, lat);
      check_output($sformatf("vec%0d_data", k), got, vecs[k].exp_data);
      check_output($sformatf("vec%0d_err", k), {31'b0, got_err}, {31'b0, vecs[k].exp_err});
      check_output($sformatf("vec%0d_latency", k), lat, 32'd5);
      check_output($sformatf("vec%0d_idle_after", k), {30'b0, out_valid, in_ready}, 32'd1);
    end

    // Randomized requests against the reference model.
    for (int r = 0; r < 40; r++) begin
      logic [31:0] d;
      logic [4:0]  s;
      logic [1:0]  op;
      d  = $urandom;
      s  = 5'($urandom_range(0, 31));
      op = 2'($urandom_range(0, 3));
      ref_model(d, s, op, exp_d, exp_e);
      apply_stimulus(d, s, op, int'($urandom_range(0, 2)), got, got_err, lat);
      check_output($sformatf("rand%0d_data", r), got, exp_d);
      check_output($sformatf("rand%0d_err", r), {31'b0, got_err}, {31'b0, exp_e});
      check_output($sformatf("rand%0d_latency", r), lat, 32'd5);
    end

    // Backpressure: consumer stalls three cycles in DONE.
    apply_stimulus(32'h1234_5678, 5'd8, 2'b01, 3, got, got_err, lat);
    check_output("bp_data", got, 32'h0012_3456);
    check_output("bp_idle_after", {30'b0, out_valid, in_ready}, 32'd1);

    // Back-to-back throughput with out_ready tied high.
    in_valid  = 1'b1;
    in_data   = 32'h0000_00F0;
    in_shamt  = 5'd4;
    in_op     = 2'b01;
    out_ready = 1'b1;
    cyc = 0;
    naccept = 0;
    t0 = 0;
    t1 = 0;
    while (naccept < 2 && cyc < 40) begin
      if (in_ready) begin
        if (naccept == 0) t0 = cyc;
        else t1 = cyc;
        naccept++;
      end
      @(negedge clk);
      cyc++;
    end
    check_output("tput_accepts", naccept, 32'd2);
    check_output("tput_spacing", t1 - t0, 32'd7);
    in_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check_output("tput_drain", {31'b0, busy}, 32'd0);

    // Reset during SHIFT step 2 aborts the operation.
    in_valid = 1'b1;
    in_data  = 32'hFFFF_0000;
    in_shamt = 5'd5;
    in_op    = 2'b01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("midrst_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_output("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check_output("midrst_busy", {31'b0, busy}, 32'd0);
    check_output("midrst_out_data", out_data, 32'd0);
    apply_stimulus(32'h0000_0010, 5'd1, 2'b01, 0, got, got_err, lat);
    check_output("midrst_fresh_data", got, 32'h0000_0008);
    check_output("midrst_fresh_latency", lat, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
